// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - command sequencer around the 12-bit ALU with a 4x12 register file
// Optional sticky overflow flag enabled by defining ALU_SEQ_STICKY_OV_EN
module alu_seq #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [1:0]   cmd_srca,
  input  logic [1:0]   cmd_srcb,
  input  logic [1:0]   cmd_dst,
  input  logic         wr_en,
  input  logic [1:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [1:0]   rd_addr,
  output logic [W-1:0] rd_data,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_z,
  input  logic         alu_carry,
  input  logic         alu_sign,
  input  logic         alu_ov,
  output logic [W-1:0] result,
  output logic [2:0]   flags,
  output logic         done,
  input  logic         ov_clr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic                 live;
  logic                 accept, capture;
  logic [3:0][W-1:0]    regs;
  logic [W-1:0]         opa, opb;
  logic [2:0]           op;
  logic [1:0]           dst;
  logic                 ov, sign, carry;

  // live keeps cmd_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nx;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = live;
        if (cmd_valid && live) begin
          accept   = 1'b1;
          state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        capture  = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa <= '0;
      opb <= '0;
      op  <= '0;
      dst <= '0;
    end else if (accept) begin
      opa <= regs[cmd_srca];
      opb <= regs[cmd_srcb];
      op  <= cmd_op;
      dst <= cmd_dst;
    end
  end

  // Writeback is ordered after the preload so it wins on a same-register collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      if (wr_en)   regs[wr_addr] <= wr_data;
      if (capture) regs[dst]     <= alu_z;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      sign   <= 1'b0;
      carry  <= 1'b0;
    end else if (capture) begin
      result <= alu_z;
      sign   <= alu_z[W-1];
      carry  <= op[2] & op[1] & alu_carry;
    end
  end

`ifdef ALU_SEQ_STICKY_OV_EN
  // A capture that sets overflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ov <= 1'b0;
    else        ov <= (capture & alu_ov) | (ov & ~ov_clr);
  end

  logic unused_in;
  assign unused_in = alu_sign;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ov <= 1'b0;
    else if (capture) ov <= alu_ov;
  end

  logic unused_in;
  assign unused_in = alu_sign ^ ov_clr;
`endif

  assign alu_a   = opa;
  assign alu_b   = opb;
  assign alu_op  = op;
  assign flags   = {ov, sign, carry};
  assign rd_data = regs[rd_addr];

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a behavioural ALU and reference model
`timescale 1ns/1ps
module tb_alu_seq;
  localparam int W = 12;
`ifdef ALU_SEQ_STICKY_OV_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [1:0]   cmd_srca = '0, cmd_srcb = '0, cmd_dst = '0;
  logic         wr_en = 1'b0;
  logic [1:0]   wr_addr = '0, rd_addr = '0;
  logic [W-1:0] wr_data = '0, rd_data;
  logic [W-1:0] alu_a, alu_b, alu_z, result;
  logic [2:0]   alu_op, flags;
  logic         alu_carry, alu_sign, alu_ov, done;
  logic         ov_clr = 1'b0;

  int n_checks = 0, n_fail = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_dst(cmd_dst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_ov(alu_ov),
    .result(result), .flags(flags), .done(done), .ov_clr(ov_clr)
  );

  // Returns {ov, carry, z}; logic ops report carry=1 so the sequencer must mask it
  function automatic logic [W+1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] z;
    logic         c, v;
    c = 1'b1;
    v = 1'b0;
    s = '0;
    case (op)
      3'd0: z = a;
      3'd1: z = b;
      3'd2: z = a & b;
      3'd3: z = a | b;
      3'd4: z = a ^ b;
      3'd5: z = ~a;
      3'd6: begin
        s = {1'b0, a} + {1'b0, b};
        z = s[W-1:0];
        c = s[W];
        v = (a[W-1] == b[W-1]) && (z[W-1] != a[W-1]);
      end
      default: begin
        s = {1'b0, a} - {1'b0, b};
        z = s[W-1:0];
        c = s[W];
        v = (a[W-1] != b[W-1]) && (z[W-1] != a[W-1]);
      end
    endcase
    return {v, c, z};
  endfunction

  logic [W+1:0] alu_out;
  assign alu_out   = alu_fn(alu_op, alu_a, alu_b);
  assign alu_z     = alu_out[W-1:0];
  assign alu_carry = alu_out[W];
  assign alu_ov    = alu_out[W+1];
  assign alu_sign  = alu_out[W-1];

  logic [W-1:0] mregs [4];
  logic [W-1:0] mres;
  logic         mov, msign, mcarry;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mregs[i] = '0;
    mres = '0; mov = 1'b0; msign = 1'b0; mcarry = 1'b0;
  endtask

  task automatic preload(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mregs[a] = d;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    ov_clr = 1'b1;
    @(negedge clk);
    ov_clr = 1'b0;
    if (STICKY) mov = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), 32'(rd_data), 32'(mregs[i]));
    end
  endtask

  // wmode: 0 no preload, 1 preload on the acceptance edge, 2 preload on the capture edge
  task automatic issue(input logic [2:0] op, input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] d,
                       input int wmode, input logic [1:0] wa, input logic [W-1:0] wd, input logic clr);
    logic [W-1:0] a, b;
    logic [W+1:0] r;
    int           waitc;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_srca = sa; cmd_srcb = sb; cmd_dst = d;
    waitc = 0;
    while (!cmd_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: cmd_ready 0, expected 1");
      cmd_valid = 1'b0;
      return;
    end
    if (wmode == 1) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
    a = mregs[sa];
    b = mregs[sb];
    if (wmode == 1) mregs[wa] = wd;
    r = alu_fn(op, a, b);
    @(negedge clk);
    cmd_valid = 1'b0; wr_en = 1'b0;
    check("exec_ready", 32'(cmd_ready), 0);
    check("exec_done", 32'(done), 0);
    check("alu_a", 32'(alu_a), 32'(a));
    check("alu_b", 32'(alu_b), 32'(b));
    check("alu_op", 32'(alu_op), 32'(op));
    if (wmode == 2) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
    ov_clr = clr;
    @(negedge clk);
    wr_en = 1'b0; ov_clr = 1'b0;
    if (wmode == 2) mregs[wa] = wd;
    mregs[d] = r[W-1:0];
    mres     = r[W-1:0];
    mcarry   = (op == 3'd6 || op == 3'd7) ? r[W] : 1'b0;
    msign    = r[W-1];
    mov      = STICKY ? (r[W+1] | (mov & ~clr)) : r[W+1];
    check("done_pulse", 32'(done), 1);
    check("done_ready", 32'(cmd_ready), 0);
    check("result", 32'(result), 32'(mres));
    check("flags", 32'(flags), 32'({mov, msign, mcarry}));
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [1:0]   sa, sb, d;
    logic [W-1:0] r0, r1, exp_res;
    logic [2:0]   exp_flags;
  } vec_t;

  vec_t       vt [10];
  logic [2:0] bop [3];
  logic [1:0] bsa [3], bsb [3], bd [3];
  int         acc [3], dn [3];
  int         na, nd;
  bit         adv;

  initial begin
    vt[0] = '{3'd6, 2'd0, 2'd1, 2'd2, 12'h7FF, 12'h001, 12'h800, 3'b110};
    vt[1] = '{3'd6, 2'd0, 2'd1, 2'd3, 12'hF0F, 12'h0FF, 12'h00E, 3'b001};
    vt[2] = '{3'd2, 2'd0, 2'd1, 2'd3, 12'hF0F, 12'h0FF, 12'h00F, 3'b000};
    vt[3] = '{3'd7, 2'd0, 2'd1, 2'd2, 12'h000, 12'h001, 12'hFFF, 3'b011};
    vt[4] = '{3'd3, 2'd0, 2'd1, 2'd1, 12'h800, 12'h001, 12'h801, 3'b010};
    vt[5] = '{3'd4, 2'd0, 2'd0, 2'd0, 12'hFFF, 12'h000, 12'h000, 3'b000};
    vt[6] = '{3'd5, 2'd0, 2'd1, 2'd2, 12'h0F0, 12'h000, 12'hF0F, 3'b010};
    vt[7] = '{3'd6, 2'd0, 2'd1, 2'd3, 12'h800, 12'h800, 12'h000, 3'b101};
    vt[8] = '{3'd7, 2'd0, 2'd1, 2'd2, 12'h800, 12'h001, 12'h7FF, 3'b100};
    vt[9] = '{3'd1, 2'd0, 2'd1, 2'd0, 12'h000, 12'hABC, 12'hABC, 3'b010};
    model_reset();

    // reset state
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_flags", 32'(flags), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(cmd_ready), 1);
    check_regs("rst");

    // directed vectors
    for (int i = 0; i < 10; i++) begin
      pulse_clr();
      preload(2'd0, vt[i].r0);
      preload(2'd1, vt[i].r1);
      issue(vt[i].op, vt[i].sa, vt[i].sb, vt[i].d, 0, 2'd0, '0, 1'b0);
      check($sformatf("vec%0d_result", i), 32'(result), 32'(vt[i].exp_res));
      check($sformatf("vec%0d_flags", i), 32'(flags), 32'(vt[i].exp_flags));
      rd_addr = vt[i].d;
      #1;
      check($sformatf("vec%0d_wb", i), 32'(rd_data), 32'(vt[i].exp_res));
    end

    // preload collisions and acceptance-edge read of old contents
    preload(2'd0, 12'h7FF);
    preload(2'd1, 12'h001);
    issue(3'd6, 2'd0, 2'd1, 2'd2, 2, 2'd2, 12'h123, 1'b0);
    rd_addr = 2'd2; #1;
    check("coll_same_r2", 32'(rd_data), 32'h800);
    preload(2'd1, 12'h001);
    issue(3'd6, 2'd0, 2'd1, 2'd2, 2, 2'd1, 12'h123, 1'b0);
    rd_addr = 2'd1; #1;
    check("coll_diff_r1", 32'(rd_data), 32'h123);
    rd_addr = 2'd2; #1;
    check("coll_diff_r2", 32'(rd_data), 32'h800);
    preload(2'd0, 12'h010);
    preload(2'd1, 12'h020);
    issue(3'd6, 2'd0, 2'd1, 2'd3, 1, 2'd0, 12'h700, 1'b0);
    check("acc_old_read", 32'(result), 32'h030);
    check_regs("coll");

    // overflow flag across ADD then AND, clear, and set-wins
    pulse_clr();
    preload(2'd0, 12'h7FF);
    preload(2'd1, 12'h001);
    issue(3'd6, 2'd0, 2'd1, 2'd2, 0, 2'd0, '0, 1'b0);
    check("ov_add", 32'(flags[2]), 1);
    preload(2'd0, 12'hF0F);
    preload(2'd1, 12'h0FF);
    issue(3'd2, 2'd0, 2'd1, 2'd3, 0, 2'd0, '0, 1'b0);
    check("ov_after_and", 32'(flags[2]), STICKY ? 32'd1 : 32'd0);
    pulse_clr();
    #1;
    check("ov_after_clr", 32'(flags[2]), 0);
    preload(2'd0, 12'h7FF);
    preload(2'd1, 12'h001);
    issue(3'd6, 2'd0, 2'd1, 2'd2, 0, 2'd0, '0, 1'b1);
    check("ov_set_wins", 32'(flags[2]), 1);

    // back-to-back with valid held high
    pulse_clr();
    preload(2'd0, 12'h005);
    preload(2'd1, 12'h003);
    bop = '{3'd6, 3'd6, 3'd7};
    bsa = '{2'd0, 2'd2, 2'd3};
    bsb = '{2'd1, 2'd1, 2'd0};
    bd  = '{2'd2, 2'd3, 2'd0};
    @(negedge clk);
    cmd_op = bop[0]; cmd_srca = bsa[0]; cmd_srcb = bsb[0]; cmd_dst = bd[0];
    cmd_valid = 1'b1;
    na = 0; nd = 0; adv = 1'b0;
    for (int c = 0; c < 40 && nd < 3; c++) begin
      if (done) begin dn[nd] = cyc; nd++; end
      if (adv) begin
        adv = 1'b0;
        if (na < 3) begin
          cmd_op = bop[na]; cmd_srca = bsa[na]; cmd_srcb = bsb[na]; cmd_dst = bd[na];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (cmd_valid && cmd_ready && na < 3) begin acc[na] = cyc; na++; adv = 1'b1; end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("b2b_accepts", 32'(na), 3);
    check("b2b_dones", 32'(nd), 3);
    if (na == 3 && nd == 3) begin
      check("b2b_acc_gap1", 32'(acc[1] - acc[0]), 3);
      check("b2b_acc_gap2", 32'(acc[2] - acc[1]), 3);
      check("b2b_done_gap1", 32'(dn[1] - dn[0]), 3);
      check("b2b_done_gap2", 32'(dn[2] - dn[1]), 3);
      check("b2b_latency", 32'(dn[0] - acc[0]), 2);
    end
    mregs[2] = 12'h008; mregs[3] = 12'h00B; mregs[0] = 12'h006;
    mres = 12'h006; mov = 1'b0; msign = 1'b0; mcarry = 1'b0;
    check("b2b_result", 32'(result), 32'h006);
    check("b2b_flags", 32'(flags), 0);
    check_regs("b2b");

    // randomized commands against the reference model
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) preload(2'($urandom_range(0, 3)), W'($urandom));
      issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
            W'($urandom), ($urandom_range(0, 3) == 0));
    end
    check_regs("rand");

    // reset asserted mid-EXEC
    preload(2'd0, 12'h555);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_srca = 2'd0; cmd_srcb = 2'd0; cmd_dst = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pre_rst_alu_a", 32'(alu_a), 32'h555);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(cmd_ready), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_result", 32'(result), 0);
    check("mid_rst_flags", 32'(flags), 0);
    check("mid_rst_alu_a", 32'(alu_a), 0);
    check("mid_rst_alu_b", 32'(alu_b), 0);
    check("mid_rst_alu_op", 32'(alu_op), 0);
    @(negedge clk);
    check("mid_rst_no_done", 32'(done), 0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("mid_rel_ready", 32'(cmd_ready), 1);
    check("mid_rel_done", 32'(done), 0);
    check_regs("mid_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
